// File: rtl/mult_hilo_unit_pkg.sv
// Shared decode constants and FSM encoding for the HI/LO multiply unit.
// These extend the opcode/function constant set used by ALU control.
package mult_hilo_unit_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] FUNC_MULT    = 6'b011000;
  localparam logic [5:0] FUNC_MFHI    = 6'b010000;
  localparam logic [5:0] FUNC_MFLO    = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_hilo_unit_shift_add_core.sv
// Shift-add datapath: operand magnitudes, accumulator, iteration count and sign fix-up.
// Sequencing is driven by the parent FSM through i_load and i_step.
module mult_shift_add_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product
);

  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_addend;

  // The most-negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
  assign w_abs_a  = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_abs_b  = i_b[WIDTH-1] ? -i_b : i_b;
  assign w_addend = {{WIDTH{1'b0}}, r_mag_a} << r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
    end else if (i_load) begin
      r_mag_a <= w_abs_a;
      r_mag_b <= w_abs_b;
      r_neg   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_step) begin
      if (r_mag_b[0]) begin
        r_acc <= r_acc + w_addend;
      end
      r_mag_b <= r_mag_b >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last    = (r_cnt == CNT_W'(WIDTH-1));
  // Negating a zero accumulator yields zero, so no special case is needed.
  assign o_product = r_neg ? -r_acc : r_acc;

endmodule

// File: rtl/mult_hilo_unit.sv
// Multiply unit owning HI/LO: decodes MULT/MFHI/MFLO, sequences the shift-add core,
// and stalls the pipeline while a product is in flight.
//   state  | meaning
//   IDLE   | waiting for MULT; HI/LO hold last committed product
//   RUN    | one shift-add iteration per cycle
//   FINISH | sign fix-up committed to HI/LO
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       inst_func,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             hilo_rsel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_e r_state;
  mult_state_e w_next_state;

  logic               w_rtype;
  logic               w_is_mult;
  logic               w_is_mfhi;
  logic               w_is_mflo;
  logic               w_load;
  logic               w_step;
  logic               w_commit;
  logic               w_last;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  assign w_rtype   = inst_valid && (opcode == OPCODE_RTYPE);
  assign w_is_mult = w_rtype && (inst_func == FUNC_MULT);
  assign w_is_mfhi = w_rtype && (inst_func == FUNC_MFHI);
  assign w_is_mflo = w_rtype && (inst_func == FUNC_MFLO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mult) begin
          w_load       = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next_state = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_commit     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  mult_shift_add_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_a       (rs_data),
    .i_b       (rt_data),
    .o_last    (w_last),
    .o_product (w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_product[2*WIDTH-1:WIDTH];
      r_lo <= w_product[WIDTH-1:0];
    end
  end

  // No bypass: a reader in the commit cycle is still stalled by busy.
  assign busy       = (r_state != ST_IDLE);
  assign stall      = busy && (w_is_mult || w_is_mfhi || w_is_mflo);
  assign hilo_rsel  = w_is_mfhi || w_is_mflo;
  assign hilo_rdata = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : '0);
  assign hi         = r_hi;
  assign lo         = r_lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit: signed products, latency, stalls, squash and reset.
module tb_mult_hilo_unit;

  localparam int WIDTH = 32;
  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] F_MUL = 6'b011000;
  localparam logic [5:0] F_MFH = 6'b010000;
  localparam logic [5:0] F_MFL = 6'b010010;

  logic             clk = 1'b0;
  logic             rst;
  logic             inst_valid;
  logic [5:0]       opcode;
  logic [5:0]       inst_func;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] hilo_rdata;
  logic             hilo_rsel;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  mult_hilo_unit dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .opcode     (opcode),
    .inst_func  (inst_func),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .hilo_rdata (hilo_rdata),
    .hilo_rsel  (hilo_rsel),
    .stall      (stall),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    inst_valid = v;
    opcode     = op;
    inst_func  = fn;
    rs_data    = a;
    rt_data    = b;
  endtask

  task automatic idle_inst;
    issue(1'b0, 6'd0, 6'd0, '0, '0);
  endtask

  // Ticks until busy drops; n is the number of edges taken (capped at 200).
  task automatic wait_not_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  // Accepts a MULT on the next edge and waits for its commit.
  task automatic do_mult(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
    int c;
    issue(1'b1, OP_R, F_MUL, a, b);
    tick();
    idle_inst();
    wait_not_busy(c);
    chk({tag, "_lat"}, WIDTH'(c), WIDTH'(WIDTH+1));
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    rst = 1'b1;
    idle_inst();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_busy", WIDTH'(busy), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    issue(1'b1, OP_R, F_MFL, '0, '0);
    #1;
    chk("rst_mflo_rsel", WIDTH'(hilo_rsel), 1);
    chk("rst_mflo_data", hilo_rdata, 0);
    chk("rst_mflo_stall", WIDTH'(stall), 0);

    // 7 x 6 with a stalled MFLO behind it
    issue(1'b1, OP_R, F_MUL, 32'd7, 32'd6);
    #1;
    chk("mul76_nostall", WIDTH'(stall), 0);
    tick();
    chk("mul76_busy", WIDTH'(busy), 1);
    issue(1'b1, OP_R, F_MFL, '0, '0);
    #1;
    chk("mflo_stall", WIDTH'(stall), 1);
    chk("mflo_old", hilo_rdata, 0);
    n = 0;
    while (stall && n < 200) begin
      tick();
      n++;
    end
    chk("mflo_stall_cycles", WIDTH'(n), WIDTH'(WIDTH+1));
    chk("mflo_data", hilo_rdata, 32'd42);
    chk("mul76_hi", hi, 0);
    chk("mul76_lo", lo, 32'd42);
    idle_inst();
    #1;
    chk("idle_rdata", hilo_rdata, 0);
    chk("idle_rsel", WIDTH'(hilo_rsel), 0);

    do_mult("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue(1'b1, OP_R, F_MFH, '0, '0);
    #1;
    chk("mfhi_data", hilo_rdata, 32'hFFFF_FFFF);
    chk("mfhi_rsel", WIDTH'(hilo_rsel), 1);

    do_mult("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_mult("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
    do_mult("neg9x0", 32'hFFFF_FFF7, 32'd0, 32'd0, 32'd0);
    do_mult("neg2xneg3", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);

    // Back-to-back: 2 x 3, then 4 x 5 held until the first drains
    issue(1'b1, OP_R, F_MUL, 32'd2, 32'd3);
    tick();
    issue(1'b1, OP_R, F_MUL, 32'd4, 32'd5);
    #1;
    chk("b2b_stall", WIDTH'(stall), 1);
    n = 0;
    while (stall && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_stall_cycles", WIDTH'(n), WIDTH'(WIDTH+1));
    chk("b2b_first_lo", lo, 32'd6);
    tick();
    idle_inst();
    chk("b2b_second_busy", WIDTH'(busy), 1);
    wait_not_busy(n);
    chk("b2b_second_lat", WIDTH'(n), WIDTH'(WIDTH+1));
    chk("b2b_lo", lo, 32'd20);
    chk("b2b_hi", hi, 32'd0);

    // Squashed MULT, wrong function code, wrong opcode: none may start
    issue(1'b0, OP_R, F_MUL, 32'd9, 32'd9);
    tick();
    chk("squash_busy", WIDTH'(busy), 0);
    issue(1'b1, OP_R, 6'b011001, 32'd9, 32'd9);
    tick();
    chk("multu_busy", WIDTH'(busy), 0);
    issue(1'b1, 6'b000001, F_MUL, 32'd9, 32'd9);
    tick();
    chk("badop_busy", WIDTH'(busy), 0);
    chk("squash_lo", lo, 32'd20);

    // Reset asserted mid-RUN at edge 10
    issue(1'b1, OP_R, F_MUL, 32'd3, 32'd3);
    tick();
    issue(1'b1, OP_R, F_MFH, '0, '0);
    repeat (9) tick();
    chk("midrun_busy", WIDTH'(busy), 1);
    chk("midrun_stall", WIDTH'(stall), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", WIDTH'(busy), 0);
    chk("rst_mid_stall", WIDTH'(stall), 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    tick();
    rst = 1'b0;
    idle_inst();
    repeat (40) tick();
    chk("post_rst_busy", WIDTH'(busy), 0);
    chk("post_rst_lo", lo, 0);

    // Normal operation resumes after reset
    do_mult("post_rst_mul", 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF9C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
